processor_debug_cmd_arbiter: RTL and testbench
==============================================

Name: processor_debug_cmd_arbiter

Overview:
- Shares the single core debug command port between two debug requesters: requester 0 is the UART debugger, requester 1 is the second debug master (breakpoint/JTAG unit).
- Arbitrates round-robin and runs one command at a time: issue, wait for the core response, route the response back to its owner.
- A requester that stops the core owns it exclusively until it restarts it.
- A response timeout ensures a requester never hangs on a silent core.

Parameters:
P_TIMEOUT, 16'd65535, WAIT-state cycles without iCORE_VALID before the command is aborted with an error.

Ports:
iCLOCK  in  1  clock
inRESET  in  1  reset, synchronous, active-low
iREQn_REQ  in  1  command request, n=0,1; held with its fields until accepted
oREQn_BUSY  out  1  requester n not accepted this cycle
iREQn_COMMAND  in  4  command code (0 RD, 1 WR, 8 GO, 9 INTGO, A STEP, F STOP)
iREQn_TARGET  in  12  register target
iREQn_DATA  in  32  write data
oREQn_VALID  out  1  one-cycle response pulse to requester n
oREQn_ERROR  out  1  response error, qualified by VALID
oREQn_DATA  out  32  response data, qualified by VALID
oCORE_REQ  out  1  command strobe to core
iCORE_BUSY  in  1  core cannot accept a command
oCORE_COMMAND  out  4  captured command
oCORE_TARGET  out  12  captured target
oCORE_DATA  out  32  captured data
iCORE_VALID  in  1  core response strobe
iCORE_ERROR  in  1  core response error
iCORE_DATA  in  32  core response data
oLOCK_VALID  out  1  core is locked to one requester
oLOCK_OWNER  out  1  index of the lock owner

Behaviour:
- Reset, when inRESET is low at a clock edge:
  - state = IDLE; timeout counter = 0; round-robin pointer last = 1 (so requester 0 wins first).
  - Lock cleared; all VALID/ERROR/DATA outputs and captured registers = 0.
  - oREQn_BUSY is forced to 1 while inRESET is low.
  - A reset mid-command abandons the command; a later iCORE_VALID is ignored.
- States: IDLE, ISSUE, WAIT.
- Eligibility:
  - Not locked: both requesters are eligible.
  - Locked: only oLOCK_OWNER is eligible; the other requester sees BUSY=1 for the whole lock.
- Grant, computed combinationally in IDLE:
  - One eligible requester with REQ=1: it is granted.
  - Both: grant !last.
- oREQn_BUSY = !(state==IDLE && grant==n).
- Acceptance: at an edge with state==IDLE and a grant, capture COMMAND/TARGET/DATA and the owner index, update last = owner, go to ISSUE. No other state changes occur in that cycle.
- ISSUE:
  - oCORE_REQ = !iCORE_BUSY (combinational).
  - Go to WAIT on the edge where oCORE_REQ=1; otherwise stay in ISSUE with no timeout.
  - oCORE_COMMAND/TARGET/DATA always drive the captured registers.
- WAIT:
  - Counter increments each cycle.
  - On iCORE_VALID: next cycle oREQowner_VALID=1 with ERROR/DATA registered from the core; state -> IDLE; counter -> 0.
  - If the counter reaches P_TIMEOUT-1 without VALID: next cycle VALID=1, ERROR=1, DATA=0; state -> IDLE.
  - iCORE_VALID in the same cycle as expiry: the core response wins.
- iCORE_VALID in IDLE or ISSUE is ignored.
- The non-owner's VALID stays 0.
- Lock update, on a real core response only (never on timeout):
  - STOP (F) completing with ERROR=0 sets lock = owner.
  - GO (8) or INTGO (9) completing with ERROR=0 clears the lock.
  - STEP, RD, WR and any errored response leave the lock unchanged.
- Latency:
  - Accept at edge k; oCORE_REQ high in cycle k+1 if the core is not busy.
  - Response pulse appears one cycle after iCORE_VALID.
  - The next accept is possible in the cycle of the response pulse.
- Only one command is outstanding at a time; no queueing.

Test Plan:
1. Single requester: REQ0 RD target 12'd5 → BUSY0=0 in IDLE; oCORE_REQ one cycle later with COMMAND=0, TARGET=5; core VALID with DATA=32'h1234_5678 → VALID0 pulse next cycle with DATA=32'h12345678, ERROR=0; VALID1 stays 0.
2. Round-robin: both requesters hold RD continuously after reset → grants alternate 0,1,0,1; each response goes only to its owner.
3. Lock: REQ1 STOP, core ERROR=0 → oLOCK_VALID=1, OWNER=1; REQ0 RD held for 100 cycles → BUSY0=1 throughout; REQ1 RD still served; REQ1 GO OK → lock clears and the pending REQ0 is accepted next IDLE.
4. Errored STOP (iCORE_ERROR=1) → VALID0 with ERROR=1; oLOCK_VALID stays 0.
5. Timeout with P_TIMEOUT=16: core silent → VALID/ERROR=1, DATA=0 sixteen cycles after entering WAIT; a late iCORE_VALID is ignored; VALID arriving exactly at expiry → core data is delivered with ERROR=iCORE_ERROR.
6. Busy and reset: iCORE_BUSY=1 for 20 cycles → oCORE_REQ stays 0 with no timeout, then issues when BUSY drops; assert inRESET during WAIT → IDLE, lock cleared, BUSY=1 during reset, no response pulse.

Source files
------------

// File: rtl/processor_debug_cmd_arbiter_if.sv
// processor_debug_cmd_arbiter_if: requester, core and lock signals of the debug command arbiter
interface processor_debug_cmd_arbiter_if;
  logic [1:0]       req;
  logic [1:0]       req_busy;
  logic [1:0][3:0]  req_command;
  logic [1:0][11:0] req_target;
  logic [1:0][31:0] req_data;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_error;
  logic [1:0][31:0] rsp_data;
  logic             core_req;
  logic             core_busy;
  logic [3:0]       core_command;
  logic [11:0]      core_target;
  logic [31:0]      core_data;
  logic             core_valid;
  logic             core_error;
  logic [31:0]      core_rdata;
  logic             lock_valid;
  logic             lock_owner;
  modport master (
    input  req, req_command, req_target, req_data, core_busy, core_valid, core_error, core_rdata,
    output req_busy, rsp_valid, rsp_error, rsp_data, core_req, core_command, core_target, core_data,
           lock_valid, lock_owner
  );
  modport slave (
    output req, req_command, req_target, req_data, core_busy, core_valid, core_error, core_rdata,
    input  req_busy, rsp_valid, rsp_error, rsp_data, core_req, core_command, core_target, core_data,
           lock_valid, lock_owner
  );
endinterface

// File: rtl/processor_debug_cmd_arbiter.sv
// processor_debug_cmd_arbiter: round-robin sharing of the core debug port between two requesters with stop-lock and response timeout
module processor_debug_cmd_arbiter #(
  parameter logic [15:0] P_TIMEOUT = 16'd65535
) (
  input logic iCLOCK,
  input logic inRESET,
  processor_debug_cmd_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t           state, state_nx;
  logic [15:0]      cnt;
  logic             last, owner;
  logic [3:0]       cmd;
  logic [11:0]      tgt;
  logic [31:0]      dat;
  logic             lock_valid, lock_owner;
  logic [1:0]       rsp_valid, rsp_error;
  logic [1:0][31:0] rsp_data;
  logic [1:0]       cand;
  logic             gnt_valid, gnt, core_req, rsp_hit, expire, done;
  // grant selection: a lock narrows eligibility to its owner, a tie goes to the requester not served last
  always_comb begin
    cand      = bus.req & (lock_valid ? (lock_owner ? 2'b10 : 2'b01) : 2'b11);
    gnt_valid = state == IDLE && |cand;
    gnt       = &cand ? ~last : cand[1];
    core_req  = state == ISSUE && !bus.core_busy;
    rsp_hit   = state == WAIT && bus.core_valid;
    expire    = state == WAIT && !bus.core_valid && cnt == P_TIMEOUT - 16'd1;
    done      = rsp_hit || expire;
  end
  // next-state: accept in IDLE, strobe the core in ISSUE, finish on a response or timeout in WAIT
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE && gnt_valid) ? ISSUE :
               (state == ISSUE && core_req) ? WAIT  :
               done                         ? IDLE  : state;
  end
  // state register; reset abandons any outstanding command
  always_ff @(posedge iCLOCK) begin
    if (!inRESET) state <= IDLE;
    else          state <= state_nx;
  end
  // command capture on acceptance, remembering the winner for round-robin and response routing
  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      last  <= 1'b1;
      owner <= 1'b0;
      cmd   <= '0;
      tgt   <= '0;
      dat   <= '0;
    end else if (gnt_valid) begin
      last  <= gnt;
      owner <= gnt;
      cmd   <= bus.req_command[gnt];
      tgt   <= bus.req_target[gnt];
      dat   <= bus.req_data[gnt];
    end
  end
  // response timeout counter, running only while waiting on the core
  always_ff @(posedge iCLOCK) begin
    if (!inRESET) cnt <= '0;
    else          cnt <= (state == WAIT && !done) ? cnt + 16'd1 : '0;
  end
  // one-cycle response pulse to the owner; a timeout reports an error with zero data
  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      rsp_valid <= '0;
      rsp_error <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= '0;
      if (done) begin
        rsp_valid[owner] <= 1'b1;
        rsp_error[owner] <= rsp_hit ? bus.core_error : 1'b1;
        rsp_data[owner]  <= rsp_hit ? bus.core_rdata : 32'd0;
      end
    end
  end
  // exclusive lock: a successful STOP grabs the core, a successful GO/INTGO releases it
  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      lock_valid <= 1'b0;
      lock_owner <= 1'b0;
    end else if (rsp_hit && !bus.core_error) begin
      if (cmd == 4'hF) begin
        lock_valid <= 1'b1;
        lock_owner <= owner;
      end else if (cmd == 4'h8 || cmd == 4'h9) begin
        lock_valid <= 1'b0;
      end
    end
  end
  assign bus.req_busy     = ~{gnt_valid & gnt, gnt_valid & ~gnt} | {2{~inRESET}};
  assign bus.core_req     = core_req;
  assign bus.core_command = cmd;
  assign bus.core_target  = tgt;
  assign bus.core_data    = dat;
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_error    = rsp_error;
  assign bus.rsp_data     = rsp_data;
  assign bus.lock_valid   = lock_valid;
  assign bus.lock_owner   = lock_owner;
endmodule

// File: tb/tb_processor_debug_cmd_arbiter.sv
// tb_processor_debug_cmd_arbiter: scenario and randomized checks of the debug command arbiter against a rule-level model
module tb_processor_debug_cmd_arbiter;
  logic iCLOCK = 1'b0;
  logic inRESET = 1'b0;
  int   checks = 0;
  int   failures = 0;
  processor_debug_cmd_arbiter_if bus();
  processor_debug_cmd_arbiter #(.P_TIMEOUT(16'd16)) dut (.iCLOCK(iCLOCK), .inRESET(inRESET), .bus(bus));
  always #5 iCLOCK = ~iCLOCK;
  task automatic cyc;
    @(posedge iCLOCK);
    @(negedge iCLOCK);
  endtask
  task automatic apply_reset;
    bus.req = '0;
    bus.core_busy = 1'b0;
    bus.core_valid = 1'b0;
    bus.core_error = 1'b0;
    bus.core_rdata = '0;
    inRESET = 1'b0;
    repeat (2) @(posedge iCLOCK);
    inRESET = 1'b1;
    @(negedge iCLOCK);
  endtask
  task automatic serve(input logic err, input logic [31:0] d);
    bus.core_busy = 1'b0;
    cyc;
    bus.core_valid = 1'b1;
    bus.core_error = err;
    bus.core_rdata = d;
    cyc;
    bus.core_valid = 1'b0;
    #1;
  endtask
  task automatic test_reset;
    inRESET = 1'b0;
    bus.req = 2'b11;
    cyc;
    cyc;
    #1;
    checks++; if (bus.req_busy !== 2'b11) begin failures++; $display("FAIL reset_busy got=%b exp=11", bus.req_busy); end
    checks++; if (bus.core_req !== 1'b0) begin failures++; $display("FAIL reset_core_req got=%b exp=0", bus.core_req); end
    checks++; if (bus.rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", bus.rsp_valid); end
    checks++; if (bus.lock_valid !== 1'b0) begin failures++; $display("FAIL reset_lock got=%b exp=0", bus.lock_valid); end
    checks++; if ({bus.core_command, bus.core_target, bus.core_data} !== 48'd0) begin failures++; $display("FAIL reset_capture got=%h exp=0", {bus.core_command, bus.core_target, bus.core_data}); end
    checks++; if (bus.rsp_data !== 64'd0 || bus.rsp_error !== 2'b00) begin failures++; $display("FAIL reset_rsp got=%h/%b exp=0/00", bus.rsp_data, bus.rsp_error); end
    inRESET = 1'b1;
    bus.req = 2'b00;
    @(negedge iCLOCK);
    bus.req = 2'b11;
    #1;
    checks++; if (bus.req_busy !== 2'b10) begin failures++; $display("FAIL reset_first_grant got=%b exp=10", bus.req_busy); end
    bus.req = 2'b00;
    #1;
    checks++; if (bus.req_busy !== 2'b11) begin failures++; $display("FAIL idle_no_req_busy got=%b exp=11", bus.req_busy); end
  endtask
  task automatic test_single;
    apply_reset;
    bus.req_command[0] = 4'h0;
    bus.req_target[0] = 12'd5;
    bus.req_data[0] = $urandom;
    bus.req = 2'b01;
    #1;
    checks++; if (bus.req_busy !== 2'b10) begin failures++; $display("FAIL single_busy got=%b exp=10", bus.req_busy); end
    cyc;
    bus.req = 2'b00;
    #1;
    checks++; if (bus.core_req !== 1'b1) begin failures++; $display("FAIL single_core_req got=%b exp=1", bus.core_req); end
    checks++; if (bus.core_command !== 4'h0 || bus.core_target !== 12'd5) begin failures++; $display("FAIL single_fields got=%h/%0d exp=0/5", bus.core_command, bus.core_target); end
    cyc;
    bus.core_valid = 1'b1;
    bus.core_error = 1'b0;
    bus.core_rdata = 32'h1234_5678;
    #1;
    checks++; if (bus.rsp_valid !== 2'b00) begin failures++; $display("FAIL single_early_valid got=%b exp=00", bus.rsp_valid); end
    cyc;
    bus.core_valid = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 2'b01) begin failures++; $display("FAIL single_valid got=%b exp=01", bus.rsp_valid); end
    checks++; if (bus.rsp_data[0] !== 32'h1234_5678 || bus.rsp_error[0] !== 1'b0) begin failures++; $display("FAIL single_data got=%h/%b exp=12345678/0", bus.rsp_data[0], bus.rsp_error[0]); end
    cyc;
    #1;
    checks++; if (bus.rsp_valid !== 2'b00) begin failures++; $display("FAIL single_pulse_width got=%b exp=00", bus.rsp_valid); end
  endtask
  task automatic test_round_robin;
    logic        w;
    logic [31:0] rd;
    apply_reset;
    bus.req_command = '0;
    bus.req_target[0] = 12'h100;
    bus.req_target[1] = 12'h201;
    bus.req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      w = (i % 2) == 1;
      #1;
      checks++; if (bus.req_busy !== (2'b11 ^ (2'b01 << w))) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", i, bus.req_busy, 2'b11 ^ (2'b01 << w)); end
      cyc;
      #1;
      checks++; if (bus.core_target !== (w ? 12'h201 : 12'h100)) begin failures++; $display("FAIL rr_target%0d got=%h exp=%h", i, bus.core_target, w ? 12'h201 : 12'h100); end
      rd = $urandom;
      serve(1'b0, rd);
      checks++; if (bus.rsp_valid !== (2'b01 << w) || bus.rsp_data[w] !== rd) begin failures++; $display("FAIL rr_rsp%0d got=%b/%h exp=%b/%h", i, bus.rsp_valid, bus.rsp_data[w], 2'b01 << w, rd); end
    end
    bus.req = 2'b00;
    cyc;
  endtask
  task automatic test_lock;
    int          bad;
    logic [31:0] rd;
    apply_reset;
    bus.req_command[1] = 4'hF;
    bus.req = 2'b10;
    cyc;
    bus.req = 2'b00;
    serve(1'b0, 32'h0);
    checks++; if (bus.rsp_valid !== 2'b10) begin failures++; $display("FAIL lock_stop_rsp got=%b exp=10", bus.rsp_valid); end
    checks++; if (bus.lock_valid !== 1'b1 || bus.lock_owner !== 1'b1) begin failures++; $display("FAIL lock_set got=%b/%b exp=1/1", bus.lock_valid, bus.lock_owner); end
    bus.req_command[0] = 4'h0;
    bus.req_target[0] = 12'h0AB;
    bus.req = 2'b01;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (bus.req_busy[0] !== 1'b1) bad++;
      cyc;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL lock_blocked busy0_low_cycles=%0d exp=0", bad); end
    bus.req_command[1] = 4'h0;
    bus.req = 2'b11;
    #1;
    checks++; if (bus.req_busy !== 2'b01) begin failures++; $display("FAIL lock_owner_grant got=%b exp=01", bus.req_busy); end
    cyc;
    bus.req = 2'b01;
    rd = $urandom;
    serve(1'b0, rd);
    checks++; if (bus.rsp_valid !== 2'b10 || bus.rsp_data[1] !== rd || bus.lock_valid !== 1'b1) begin failures++; $display("FAIL lock_owner_rd got=%b/%h/%b exp=10/%h/1", bus.rsp_valid, bus.rsp_data[1], bus.lock_valid, rd); end
    bus.req_command[1] = 4'h8;
    bus.req = 2'b11;
    #1;
    checks++; if (bus.req_busy !== 2'b01) begin failures++; $display("FAIL lock_go_grant got=%b exp=01", bus.req_busy); end
    cyc;
    bus.req = 2'b01;
    serve(1'b0, 32'h0);
    checks++; if (bus.rsp_valid !== 2'b10 || bus.lock_valid !== 1'b0) begin failures++; $display("FAIL lock_clear got=%b/%b exp=10/0", bus.rsp_valid, bus.lock_valid); end
    checks++; if (bus.req_busy !== 2'b10) begin failures++; $display("FAIL lock_pending_grant got=%b exp=10", bus.req_busy); end
    cyc;
    bus.req = 2'b00;
    #1;
    checks++; if (bus.core_req !== 1'b1 || bus.core_target !== 12'h0AB) begin failures++; $display("FAIL lock_pending_issue got=%b/%h exp=1/0ab", bus.core_req, bus.core_target); end
    serve(1'b0, 32'h55);
    checks++; if (bus.rsp_valid !== 2'b01) begin failures++; $display("FAIL lock_pending_rsp got=%b exp=01", bus.rsp_valid); end
  endtask
  task automatic test_err_stop;
    apply_reset;
    bus.req_command[0] = 4'hF;
    bus.req = 2'b01;
    cyc;
    bus.req = 2'b00;
    serve(1'b1, 32'hDEAD_0001);
    checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_error[0] !== 1'b1) begin failures++; $display("FAIL err_stop_rsp got=%b/%b exp=01/1", bus.rsp_valid, bus.rsp_error[0]); end
    checks++; if (bus.lock_valid !== 1'b0) begin failures++; $display("FAIL err_stop_lock got=%b exp=0", bus.lock_valid); end
  endtask
  task automatic test_timeout;
    int          bad;
    logic [31:0] rd;
    apply_reset;
    bus.req_command[0] = 4'h0;
    bus.req = 2'b01;
    cyc;
    bus.req = 2'b00;
    cyc;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      #1;
      if (bus.rsp_valid !== 2'b00) bad++;
      cyc;
    end
    #1;
    checks++; if (bad != 0 || bus.rsp_valid !== 2'b00) begin failures++; $display("FAIL timeout_early early_pulses=%0d got=%b exp=00", bad, bus.rsp_valid); end
    cyc;
    #1;
    checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_error[0] !== 1'b1 || bus.rsp_data[0] !== 32'd0) begin failures++; $display("FAIL timeout_rsp got=%b/%b/%h exp=01/1/0", bus.rsp_valid, bus.rsp_error[0], bus.rsp_data[0]); end
    bus.core_valid = 1'b1;
    bus.core_rdata = 32'hBAD0_BAD0;
    cyc;
    bus.core_valid = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 2'b00) begin failures++; $display("FAIL timeout_late_valid got=%b exp=00", bus.rsp_valid); end
    bus.req = 2'b01;
    cyc;
    bus.req = 2'b00;
    cyc;
    repeat (15) cyc;
    rd = $urandom;
    bus.core_valid = 1'b1;
    bus.core_error = 1'b0;
    bus.core_rdata = rd;
    cyc;
    bus.core_valid = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_error[0] !== 1'b0 || bus.rsp_data[0] !== rd) begin failures++; $display("FAIL timeout_race got=%b/%b/%h exp=01/0/%h", bus.rsp_valid, bus.rsp_error[0], bus.rsp_data[0], rd); end
    cyc;
  endtask
  task automatic test_busy_reset;
    int bad;
    apply_reset;
    bus.req_command[1] = 4'hF;
    bus.req = 2'b10;
    cyc;
    bus.req = 2'b00;
    serve(1'b0, 32'h0);
    bus.req_command[1] = 4'h1;
    bus.req_data[1] = 32'hA5A5_0F0F;
    bus.core_busy = 1'b1;
    bus.req = 2'b10;
    cyc;
    bus.req = 2'b00;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.core_req !== 1'b0 || bus.rsp_valid !== 2'b00) bad++;
      cyc;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL busy_hold bad_cycles=%0d exp=0", bad); end
    bus.core_busy = 1'b0;
    #1;
    checks++; if (bus.core_req !== 1'b1 || bus.core_data !== 32'hA5A5_0F0F) begin failures++; $display("FAIL busy_release got=%b/%h exp=1/a5a50f0f", bus.core_req, bus.core_data); end
    cyc;
    cyc;
    inRESET = 1'b0;
    bus.req = 2'b11;
    #1;
    checks++; if (bus.req_busy !== 2'b11) begin failures++; $display("FAIL reset_wait_busy got=%b exp=11", bus.req_busy); end
    cyc;
    #1;
    checks++; if (bus.lock_valid !== 1'b0 || bus.rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_wait_clear got=%b/%b exp=0/00", bus.lock_valid, bus.rsp_valid); end
    inRESET = 1'b1;
    bus.req = 2'b00;
    bus.core_valid = 1'b1;
    bus.core_rdata = 32'h1111_2222;
    cyc;
    bus.core_valid = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_stale_valid got=%b exp=00", bus.rsp_valid); end
    bus.req = 2'b01;
    #1;
    checks++; if (bus.req_busy !== 2'b10) begin failures++; $display("FAIL reset_back_idle got=%b exp=10", bus.req_busy); end
    bus.req = 2'b00;
    cyc;
  endtask
  task automatic test_random;
    logic [3:0]  tab [6] = '{4'h0, 4'h1, 4'h8, 4'h9, 4'hA, 4'hF};
    logic [3:0]  c [2];
    logic [11:0] t [2];
    logic [31:0] d [2];
    logic [1:0]  mask, cand;
    logic        m_lock, m_owner, m_last, w, err;
    logic [31:0] rd;
    int          k, lat;
    apply_reset;
    m_lock = 1'b0;
    m_owner = 1'b0;
    m_last = 1'b1;
    for (int it = 0; it < 150; it++) begin
      mask = 2'($urandom_range(0, 3));
      for (int r = 0; r < 2; r++) begin
        c[r] = tab[$urandom_range(0, 5)];
        t[r] = 12'($urandom);
        d[r] = $urandom;
        bus.req_command[r] = c[r];
        bus.req_target[r] = t[r];
        bus.req_data[r] = d[r];
      end
      bus.req = mask;
      cand = mask & (m_lock ? (2'b01 << m_owner) : 2'b11);
      #1;
      if (cand == 2'b00) begin
        checks++; if (bus.req_busy !== 2'b11) begin failures++; $display("FAIL rnd%0d_no_grant got=%b exp=11", it, bus.req_busy); end
        bus.req = 2'b00;
        @(negedge iCLOCK);
        continue;
      end
      w = (cand == 2'b11) ? ~m_last : cand[1];
      checks++; if (bus.req_busy !== (2'b11 ^ (2'b01 << w))) begin failures++; $display("FAIL rnd%0d_grant got=%b exp=%b", it, bus.req_busy, 2'b11 ^ (2'b01 << w)); end
      cyc;
      bus.req = 2'b00;
      k = $urandom_range(0, 3);
      bus.core_busy = 1'b1;
      for (int i = 0; i < k; i++) begin
        #1;
        checks++; if (bus.core_req !== 1'b0) begin failures++; $display("FAIL rnd%0d_busy_req got=%b exp=0", it, bus.core_req); end
        cyc;
      end
      bus.core_busy = 1'b0;
      #1;
      checks++; if ({bus.core_req, bus.core_command, bus.core_target, bus.core_data} !== {1'b1, c[w], t[w], d[w]}) begin failures++; $display("FAIL rnd%0d_issue got=%h exp=%h", it, {bus.core_req, bus.core_command, bus.core_target, bus.core_data}, {1'b1, c[w], t[w], d[w]}); end
      cyc;
      lat = $urandom_range(0, 6);
      for (int i = 0; i < lat; i++) begin
        #1;
        checks++; if (bus.rsp_valid !== 2'b00) begin failures++; $display("FAIL rnd%0d_early_rsp got=%b exp=00", it, bus.rsp_valid); end
        cyc;
      end
      err = $urandom_range(0, 3) == 0;
      rd = $urandom;
      bus.core_valid = 1'b1;
      bus.core_error = err;
      bus.core_rdata = rd;
      cyc;
      bus.core_valid = 1'b0;
      #1;
      checks++; if (bus.rsp_valid !== (2'b01 << w) || bus.rsp_error[w] !== err || bus.rsp_data[w] !== rd) begin failures++; $display("FAIL rnd%0d_rsp got=%b/%b/%h exp=%b/%b/%h", it, bus.rsp_valid, bus.rsp_error[w], bus.rsp_data[w], 2'b01 << w, err, rd); end
      m_last = w;
      if (!err && c[w] == 4'hF) begin
        m_lock = 1'b1;
        m_owner = w;
      end
      if (!err && (c[w] == 4'h8 || c[w] == 4'h9)) m_lock = 1'b0;
      checks++; if (bus.lock_valid !== m_lock || (m_lock && bus.lock_owner !== m_owner)) begin failures++; $display("FAIL rnd%0d_lock got=%b/%b exp=%b/%b", it, bus.lock_valid, bus.lock_owner, m_lock, m_owner); end
      @(negedge iCLOCK);
    end
  endtask
  initial begin
    bus.req = '0;
    bus.req_command = '0;
    bus.req_target = '0;
    bus.req_data = '0;
    bus.core_busy = 1'b0;
    bus.core_valid = 1'b0;
    bus.core_error = 1'b0;
    bus.core_rdata = '0;
    @(negedge iCLOCK);
    test_reset;
    test_single;
    test_round_robin;
    test_lock;
    test_err_stop;
    test_timeout;
    test_busy_reset;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
